sense_scheduler: RTL and testbench
==================================

# sense_scheduler

Time-multiplexes the shared 8-bit sensor/camera input bus of the precision-farming ASIC between periodic environmental-sensor sweeps and on-demand camera frame captures. It drives the sensor select lines, qualifies bus bytes as sensor samples or camera pixels for the downstream CNN/alert logic, and arbitrates fairly when both kinds of work are pending. It sits between the chip pins and the main processor datapath.

## Interface

- `SAMPLE_PERIOD`, 1024: cycles between sweep requests; must be ≥ 2.
- `SETTLE_CYCLES`, 4: cycles a sensor select is held before sampling; must be ≥ 1.
- `FRAME_TIMEOUT`, 4095: maximum cycles spent waiting for a frame start.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: when high, the period counter runs and new operations may start.
- `bus_data` in 8: shared sensor/pixel bus.
- `cam_href` in 1: camera line-valid.
- `cam_vsync` in 1: camera frame sync, high between frames.
- `frame_req` in 1: one-cycle request for a frame capture.
- `sensor_sel` out 2: active sensor channel (0–2).
- `sample_valid` out 1: one-cycle strobe; `sample_data` and `sample_id` are valid.
- `sample_data` out 8: registered sensor byte.
- `sample_id` out 2: channel of `sample_data`.
- `pixel_valid` out 1: high while capturing and `cam_href` is high.
- `pixel_count` out 16: pixels in the current or last frame, saturating at 0xFFFF.
- `frame_done` out 1: one-cycle pulse at end of frame.
- `frame_timeout` out 1: one-cycle pulse when a frame wait is abandoned.
- `overrun` out 1: sticky flag; a sweep request arrived while one was still pending.
- `busy` out 1: state is not IDLE.

## Operation

- **FSM states:** IDLE, SETTLE, SAMPLE, FRAME_WAIT, FRAME_CAPTURE.
- **Period counter:**
  - 0..`SAMPLE_PERIOD`-1; increments only while `enable` is high.
  - When it wraps, `sweep_pending` is set.
  - If `sweep_pending` is already set at the wrap, `overrun` is set instead. `overrun` clears only on reset.
- **Frame requests:** `frame_req` sets `frame_pending` in any state. Repeated requests while pending are absorbed.
- **IDLE with `enable` high:**
  - Only `sweep_pending` set: start a sweep.
  - Only `frame_pending` set: go to FRAME_WAIT.
  - Both set: serve the type not served last, tracked by `last_served`. `last_served` resets to "frame", so the sweep goes first.
  - The pending flag of the chosen type clears on the transition.
- **Sweep:**
  - For id = 0, 1, 2: SETTLE holds `sensor_sel`=id for `SETTLE_CYCLES` cycles, then SAMPLE lasts 1 cycle.
  - In SAMPLE, `sample_data` is loaded from `bus_data` and `sample_id` is set to id. `sample_valid` pulses on the next cycle.
  - After id 2, return to IDLE. `sensor_sel` returns to 0.
- **FRAME_WAIT:**
  - A falling edge of `cam_vsync` (previous cycle 1, current cycle 0) moves to FRAME_CAPTURE and clears `pixel_count`.
  - After `FRAME_TIMEOUT` cycles in FRAME_WAIT without that edge, pulse `frame_timeout` and return to IDLE. The request is dropped.
- **FRAME_CAPTURE:**
  - `pixel_valid` = `cam_href` (combinational from the state register and the input).
  - `pixel_count` increments on each valid pixel.
  - A rising edge of `cam_vsync` pulses `frame_done` and returns to IDLE.
- **No preemption:** a sweep or frame, once started, always completes. `enable` going low does not abort it.
- **`cam_vsync` edge detector:** its history register updates every cycle in every state.

## Timing

- **Reset values:** all outputs are 0, the state is IDLE, the period counter is 0, both pending flags are clear, `last_served` = frame, and the vsync history register is 0.
- **First sweep request:** `sweep_pending` is set at the edge ending the `SAMPLE_PERIOD`-th enabled cycle after reset release.
- **IDLE latency:** IDLE acts on a pending flag one cycle after the flag is set, so `busy` rises one cycle later.
- **Sweep length:** 3×(`SETTLE_CYCLES`+1) cycles.
- **Sample strobes:** `sample_valid` for id k is high in cycle k×(`SETTLE_CYCLES`+1)+`SETTLE_CYCLES`+1, counting from the first SETTLE cycle as cycle 0.
- **Frame end:** `frame_done` and `frame_timeout` rise the cycle after the detecting edge/count, coincident with the return to IDLE.
- **Frame start:** the first pixel can be captured in the cycle after the vsync falling edge is detected.
- **Simultaneous events:**
  - A `frame_req` arriving in the same cycle the frame path clears `frame_pending` re-sets it; the set wins.
  - A counter wrap arriving in the same cycle a sweep starts re-sets `sweep_pending`.
- **Mid-operation reset:** an asynchronous reset mid-operation returns everything to reset values immediately. No partial strobes are produced afterwards.

## Test plan

All scenarios use `SAMPLE_PERIOD`=16, `SETTLE_CYCLES`=2, `FRAME_TIMEOUT`=20.

- **Basic sweep:** reset release, `enable`=1, `bus_data` = 0xA0+`sensor_sel` → `sample_valid` pulses three times with (id, data) = (0,0xA0), (1,0xA1), (2,0xA2), 3 cycles apart; `busy` falls after 9 cycles; `sensor_sel` returns to 0.
- **Fair arbitration:** `frame_req` while a sweep is running and a second sweep request pending at sweep end → frame is served next, then the sweep.
- **Frame capture:** vsync 1→0, 5 cycles with `cam_href`=1, vsync 0→1 → `pixel_valid` high 5 cycles, `pixel_count`=5, `frame_done` single pulse, state IDLE.
- **Frame timeout:** `frame_req` with `cam_vsync` held 0 → `frame_timeout` pulses 20 cycles after FRAME_WAIT entry; no `frame_done`; `frame_pending` clear.
- **Overrun:** long frame (more than 32 cycles) blocks two period wraps → `overrun`=1 and sticky; exactly one sweep follows the frame.
- **Reset mid-sweep:** `rst_n` low during SETTLE of id 1 → outputs go to 0 immediately; no `sample_valid` until the next full period.

Source files
------------

// File: rtl/sense_scheduler.sv
// ============================================================================
// Module   : sense_scheduler
// Purpose  : Time-multiplexes the shared 8-bit sensor/camera bus between
//            periodic three-channel sensor sweeps and on-demand camera frame
//            captures, with fair arbitration when both are pending.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sense_scheduler #(
  parameter int SAMPLE_PERIOD = 1024,
  parameter int SETTLE_CYCLES = 4,
  parameter int FRAME_TIMEOUT = 4095
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [7:0]  bus_data,
  input  logic        cam_href,
  input  logic        cam_vsync,
  input  logic        frame_req,
  output logic [1:0]  sensor_sel,
  output logic        sample_valid,
  output logic [7:0]  sample_data,
  output logic [1:0]  sample_id,
  output logic        pixel_valid,
  output logic [15:0] pixel_count,
  output logic        frame_done,
  output logic        frame_timeout,
  output logic        overrun,
  output logic        busy
);

  localparam int c_PW = $clog2(SAMPLE_PERIOD);
  localparam int c_SW = $clog2(SETTLE_CYCLES + 1);
  localparam int c_TW = $clog2(FRAME_TIMEOUT + 1);

  localparam logic [c_PW-1:0] c_PERIOD_LAST = c_PW'(SAMPLE_PERIOD - 1);
  localparam logic [c_SW-1:0] c_SETTLE_LAST = c_SW'(SETTLE_CYCLES - 1);
  localparam logic [c_TW-1:0] c_TOUT_LAST   = c_TW'(FRAME_TIMEOUT - 1);
  localparam logic [1:0]      c_LAST_ID     = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE          = 3'd0,
    S_SETTLE        = 3'd1,
    S_SAMPLE        = 3'd2,
    S_FRAME_WAIT    = 3'd3,
    S_FRAME_CAPTURE = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [c_PW-1:0]   period_q, period_d;
  logic [c_SW-1:0]   settle_q, settle_d;
  logic [c_TW-1:0]   tout_q, tout_d;
  logic [1:0]        id_q, id_d;
  logic              sweep_pend_q, sweep_pend_d;
  logic              frame_pend_q, frame_pend_d;
  logic              last_frame_q, last_frame_d;   // 1: frame was served last
  logic              overrun_q, overrun_d;
  logic              vsync_q, vsync_d;
  logic              sample_valid_q, sample_valid_d;
  logic [7:0]        sample_data_q, sample_data_d;
  logic [1:0]        sample_id_q, sample_id_d;
  logic [15:0]       pixel_count_q, pixel_count_d;
  logic              frame_done_q, frame_done_d;
  logic              frame_timeout_q, frame_timeout_d;

  logic wrap, vs_fall, vs_rise, start_sweep, start_frame;

  // Next-state logic: period counter, pending flags, FSM and output strobes.
  always_comb begin
    state_d         = state_q;
    period_d        = period_q;
    settle_d        = settle_q;
    tout_d          = tout_q;
    id_d            = id_q;
    sweep_pend_d    = sweep_pend_q;
    frame_pend_d    = frame_pend_q;
    last_frame_d    = last_frame_q;
    overrun_d       = overrun_q;
    vsync_d         = cam_vsync;
    sample_valid_d  = 1'b0;
    sample_data_d   = sample_data_q;
    sample_id_d     = sample_id_q;
    pixel_count_d   = pixel_count_q;
    frame_done_d    = 1'b0;
    frame_timeout_d = 1'b0;
    start_sweep     = 1'b0;
    start_frame     = 1'b0;

    wrap    = enable && (period_q == c_PERIOD_LAST);
    vs_fall = vsync_q && !cam_vsync;
    vs_rise = !vsync_q && cam_vsync;

    if (enable) begin
      period_d = wrap ? '0 : period_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          // When both are pending, alternate away from the type served last.
          if (sweep_pend_q && (!frame_pend_q || last_frame_q)) begin
            start_sweep = 1'b1;
          end else if (frame_pend_q) begin
            start_frame = 1'b1;
          end
        end
        if (start_sweep) begin
          state_d      = S_SETTLE;
          id_d         = 2'd0;
          settle_d     = '0;
          last_frame_d = 1'b0;
          sweep_pend_d = 1'b0;
        end else if (start_frame) begin
          state_d      = S_FRAME_WAIT;
          tout_d       = '0;
          last_frame_d = 1'b1;
          frame_pend_d = 1'b0;
        end
      end
      S_SETTLE: begin
        if (settle_q == c_SETTLE_LAST) begin
          state_d = S_SAMPLE;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      S_SAMPLE: begin
        sample_data_d  = bus_data;
        sample_id_d    = id_q;
        sample_valid_d = 1'b1;
        if (id_q == c_LAST_ID) begin
          state_d = S_IDLE;
          id_d    = 2'd0;
        end else begin
          state_d  = S_SETTLE;
          id_d     = id_q + 2'd1;
          settle_d = '0;
        end
      end
      S_FRAME_WAIT: begin
        // A vsync fall on the final wait cycle still starts the frame.
        if (vs_fall) begin
          state_d       = S_FRAME_CAPTURE;
          pixel_count_d = '0;
        end else if (tout_q == c_TOUT_LAST) begin
          state_d         = S_IDLE;
          frame_timeout_d = 1'b1;
        end else begin
          tout_d = tout_q + 1'b1;
        end
      end
      S_FRAME_CAPTURE: begin
        if (cam_href && (pixel_count_q != 16'hFFFF)) begin
          pixel_count_d = pixel_count_q + 16'd1;
        end
        if (vs_rise) begin
          state_d      = S_IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Late-arriving requests win over the clear performed on a start.
    if (wrap) begin
      if (sweep_pend_q && !start_sweep) begin
        overrun_d = 1'b1;
      end
      sweep_pend_d = 1'b1;
    end
    if (frame_req) begin
      frame_pend_d = 1'b1;
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      period_q        <= '0;
      settle_q        <= '0;
      tout_q          <= '0;
      id_q            <= 2'd0;
      sweep_pend_q    <= 1'b0;
      frame_pend_q    <= 1'b0;
      last_frame_q    <= 1'b1;
      overrun_q       <= 1'b0;
      vsync_q         <= 1'b0;
      sample_valid_q  <= 1'b0;
      sample_data_q   <= 8'd0;
      sample_id_q     <= 2'd0;
      pixel_count_q   <= 16'd0;
      frame_done_q    <= 1'b0;
      frame_timeout_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      period_q        <= period_d;
      settle_q        <= settle_d;
      tout_q          <= tout_d;
      id_q            <= id_d;
      sweep_pend_q    <= sweep_pend_d;
      frame_pend_q    <= frame_pend_d;
      last_frame_q    <= last_frame_d;
      overrun_q       <= overrun_d;
      vsync_q         <= vsync_d;
      sample_valid_q  <= sample_valid_d;
      sample_data_q   <= sample_data_d;
      sample_id_q     <= sample_id_d;
      pixel_count_q   <= pixel_count_d;
      frame_done_q    <= frame_done_d;
      frame_timeout_q <= frame_timeout_d;
    end
  end

  assign sensor_sel    = id_q;
  assign sample_valid  = sample_valid_q;
  assign sample_data   = sample_data_q;
  assign sample_id     = sample_id_q;
  assign pixel_valid   = (state_q == S_FRAME_CAPTURE) && cam_href;
  assign pixel_count   = pixel_count_q;
  assign frame_done    = frame_done_q;
  assign frame_timeout = frame_timeout_q;
  assign overrun       = overrun_q;
  assign busy          = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_sense_scheduler.sv
// ============================================================================
// Module   : tb_sense_scheduler
// Purpose  : Scoreboard bench for sense_scheduler (period 16, settle 2,
//            frame timeout 20). Expected strobes are queued with their cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sense_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        cam_href = 1'b0;
  logic        cam_vsync = 1'b0;
  logic        frame_req = 1'b0;
  logic [7:0]  bus_data;
  logic [1:0]  sensor_sel;
  logic        sample_valid;
  logic [7:0]  sample_data;
  logic [1:0]  sample_id;
  logic        pixel_valid;
  logic [15:0] pixel_count;
  logic        frame_done;
  logic        frame_timeout;
  logic        overrun;
  logic        busy;

  sense_scheduler #(
    .SAMPLE_PERIOD(16),
    .SETTLE_CYCLES(2),
    .FRAME_TIMEOUT(20)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .bus_data(bus_data),
    .cam_href(cam_href), .cam_vsync(cam_vsync), .frame_req(frame_req),
    .sensor_sel(sensor_sel), .sample_valid(sample_valid),
    .sample_data(sample_data), .sample_id(sample_id),
    .pixel_valid(pixel_valid), .pixel_count(pixel_count),
    .frame_done(frame_done), .frame_timeout(frame_timeout),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  // Cycle n is the interval after the n-th rising edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Each sensor channel presents a distinct byte.
  assign bus_data = 8'hA0 + {6'd0, sensor_sel};

  typedef struct {
    int kind;   // 0 sample, 1 frame_done, 2 frame_timeout
    int cyc;
    int a;      // sample id or pixel count
    int d;      // sample data
  } evt_t;

  evt_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(int kind, int c, int a, int d);
    evt_t e;
    e.kind = kind; e.cyc = c; e.a = a; e.d = d;
    exp_q.push_back(e);
  endtask

  // Three samples, strobed 3, 6 and 9 cycles after the first SETTLE cycle.
  task automatic push_sweep(int first_settle);
    push(0, first_settle + 3, 0, 'hA0);
    push(0, first_settle + 6, 1, 'hA1);
    push(0, first_settle + 9, 2, 'hA2);
  endtask

  task automatic got(int kind, int a, int d);
    evt_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d payload 0x%0h at cycle %0d, expected none",
               kind, a * 256 + d, cyc);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_cycle", cyc, e.cyc);
      chk("event_payload", a * 256 + d, e.a * 256 + e.d);
    end
  endtask

  // Monitor: every output strobe is matched against the head of the queue.
  always @(negedge clk) begin
    if (sample_valid)  got(0, int'(sample_id), int'(sample_data));
    if (frame_done)    got(1, int'(pixel_count), 0);
    if (frame_timeout) got(2, 0, 0);
  end

  task automatic at(int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic do_reset(output int b);
    @(negedge clk);
    rst_n = 1'b0; enable = 1'b0; frame_req = 1'b0; cam_href = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_ctrl", int'({sensor_sel, sample_valid, sample_id, pixel_valid,
                            frame_done, frame_timeout, overrun, busy}), 0);
    chk("reset_data", int'({sample_data, pixel_count}), 0);
    chk("queue_drained", exp_q.size(), 0);
    @(negedge clk);
    rst_n = 1'b1; enable = 1'b1;
    b = cyc;
  endtask

  initial begin
    int b;

    // Basic sweep: pending visible at b+16, SETTLE from b+17, nine busy cycles.
    cam_vsync = 1'b1;
    do_reset(b);
    push_sweep(b + 17);
    for (int n = 0; n <= 27; n++) begin
      at(b + n);
      #1;
      case (n)
        16: chk("sweep_busy_latency", int'(busy), 0);
        17: chk("sweep_busy_rise", int'(busy), 1);
        21: chk("sweep_sel_id1", int'(sensor_sel), 1);
        25: chk("sweep_busy_last", int'(busy), 1);
        26: begin
          chk("sweep_busy_fall", int'(busy), 0);
          chk("sweep_sel_return", int'(sensor_sel), 0);
        end
        default: ;
      endcase
    end

    // Capture of 5 pixels, then fair alternation: sweep, frame, sweep.
    cam_vsync = 1'b1;
    do_reset(b);
    push(1, b + 28, 5, 0);
    push_sweep(b + 29);
    push(1, b + 43, 0, 0);
    push_sweep(b + 44);
    for (int n = 0; n <= 53; n++) begin
      at(b + n);
      frame_req = (n == 0) || (n == 30);
      cam_href  = (n >= 3) && (n <= 8);
      if (n == 3)  cam_vsync = 1'b0;
      if (n == 27) cam_vsync = 1'b1;
      if (n == 40) cam_vsync = 1'b0;
      if (n == 42) cam_vsync = 1'b1;
      #1;
      case (n)
        3: chk("pix_valid_in_wait", int'(pixel_valid), 0);
        4, 5, 6, 7, 8: chk("pix_valid_capture", int'(pixel_valid), 1);
        9: begin
          chk("pix_valid_after", int'(pixel_valid), 0);
          chk("pix_count", int'(pixel_count), 5);
        end
        28: chk("arb_idle_after_frame", int'(busy), 0);
        38: chk("arb_idle_after_sweep", int'(busy), 0);
        39: begin
          chk("arb_frame_next", int'(busy), 1);
          chk("arb_frame_sel", int'(sensor_sel), 0);
        end
        53: chk("arb_overrun_clear", int'(overrun), 0);
        default: ;
      endcase
    end

    // Frame timeout: wait entered at b+2, pulse at b+22, request dropped.
    cam_vsync = 1'b0;
    do_reset(b);
    push(2, b + 22, 0, 0);
    push_sweep(b + 23);
    for (int n = 0; n <= 40; n++) begin
      at(b + n);
      frame_req = (n == 0);
      if (n == 24) enable = 1'b0;
      if (n == 34) enable = 1'b1;
      #1;
      case (n)
        21: chk("tout_still_waiting", int'(busy), 1);
        22: chk("tout_idle", int'(busy), 0);
        35: chk("tout_req_dropped", int'(busy), 0);
        38: chk("tout_req_dropped2", int'(busy), 0);
        default: ;
      endcase
    end

    // Overrun: a 34-cycle frame spans wraps at b+16 and b+32.
    cam_vsync = 1'b1;
    do_reset(b);
    push(1, b + 36, 3, 0);
    push_sweep(b + 37);
    for (int n = 0; n <= 48; n++) begin
      at(b + n);
      frame_req = (n == 0);
      cam_href  = (n >= 10) && (n <= 12);
      if (n == 3)  cam_vsync = 1'b0;
      if (n == 35) cam_vsync = 1'b1;
      #1;
      case (n)
        31: chk("overrun_before", int'(overrun), 0);
        32: chk("overrun_set", int'(overrun), 1);
        47: begin
          chk("overrun_sticky", int'(overrun), 1);
          chk("overrun_one_sweep", int'(busy), 0);
        end
        48: chk("overrun_one_sweep2", int'(busy), 0);
        default: ;
      endcase
    end

    // Reset during SETTLE of id 1, then a clean sweep one full period later.
    cam_vsync = 1'b0;
    do_reset(b);
    push(0, b + 20, 0, 'hA0);
    for (int n = 0; n <= 21; n++) begin
      at(b + n);
      #1;
      if (n == 21) begin
        chk("midrst_sel_before", int'(sensor_sel), 1);
        chk("midrst_busy_before", int'(busy), 1);
      end
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_ctrl", int'({sensor_sel, sample_valid, sample_id, busy}), 0);
    chk("midrst_data", int'(sample_data), 0);
    do_reset(b);
    push_sweep(b + 17);
    for (int n = 0; n <= 27; n++) begin
      at(b + n);
      #1;
      case (n)
        16: chk("midrst_no_early_sweep", int'(busy), 0);
        26: chk("midrst_sweep_done", int'(busy), 0);
        default: ;
      endcase
    end

    @(negedge clk);
    #1;
    chk("queue_empty_end", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
